// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache sitting between the IF
// stage and memCtrl; hits return next cycle, misses refill through memCtrl.
module icache #(
    parameter int INDEX_BITS = 5,
    parameter int TAG_BITS   = 32 - INDEX_BITS - 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        IFreq_in,
    input  logic [31:0] IFpc_in,
    input  logic        flush_in,
    output logic        busy_out,
    output logic        instE_out,
    output logic [31:0] inst_out,
    output logic        memReq_out,
    output logic [31:0] memAddr_out,
    input  logic        memInstE_in,
    input  logic [31:0] memInst_in
);

    localparam int LINES = 1 << INDEX_BITS;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MISS = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]          state_reg;
    logic [LINES-1:0]    valid_reg;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  hit;
    logic                  accept;
    logic                  fill_we;
    logic                  unused_pc_bits;

    assign req_index  = IFpc_in[INDEX_BITS+1:2];
    assign req_tag    = IFpc_in[31:INDEX_BITS+2];
    // The latched miss address doubles as the refill index/tag holder.
    assign fill_index = memAddr_out[INDEX_BITS+1:2];
    assign fill_tag   = memAddr_out[31:INDEX_BITS+2];
    assign unused_pc_bits = ^IFpc_in[1:0];

    assign hit     = valid_reg[req_index] && (tag_mem[req_index] == req_tag);
    assign accept  = rdy_in && (state_reg == IDLE) && IFreq_in && !flush_in;
    // Flush wins over a same-cycle refill: the line is left untouched.
    assign fill_we = rdy_in && (state_reg == MISS) && memInstE_in && !flush_in;

    assign busy_out = (state_reg != IDLE);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_reg <= '0;
        end else if (fill_we) begin
            valid_reg[fill_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (fill_we) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= memInst_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg   <= IDLE;
            instE_out   <= 1'b0;
            inst_out    <= 32'h0;
            memReq_out  <= 1'b0;
            memAddr_out <= 32'h0;
        end else if (rdy_in) begin
            instE_out <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            inst_out  <= data_mem[req_index];
                            instE_out <= 1'b1;
                        end else begin
                            memAddr_out <= {IFpc_in[31:2], 2'b00};
                            memReq_out  <= 1'b1;
                            state_reg   <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (flush_in) begin
                        memReq_out <= 1'b0;
                        state_reg  <= WAIT;
                    end else if (memInstE_in) begin
                        inst_out   <= memInst_in;
                        instE_out  <= 1'b1;
                        memReq_out <= 1'b0;
                        state_reg  <= WAIT;
                    end
                end
                // Gives memCtrl one cycle to drop its registered IFinstE_out.
                WAIT: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg  <= IDLE;
                    memReq_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache: cold/conflict misses, hits, flush,
// rdy_in stalls and asynchronous reset during a refill.
module tb_icache;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        IFreq_in;
    logic [31:0] IFpc_in;
    logic        flush_in;
    logic        busy_out;
    logic        instE_out;
    logic [31:0] inst_out;
    logic        memReq_out;
    logic [31:0] memAddr_out;
    logic        memInstE_in;
    logic [31:0] memInst_in;

    int n_vec = 0;
    int n_err = 0;

    icache #(.INDEX_BITS(5)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .IFreq_in    (IFreq_in),
        .IFpc_in     (IFpc_in),
        .flush_in    (flush_in),
        .busy_out    (busy_out),
        .instE_out   (instE_out),
        .inst_out    (inst_out),
        .memReq_out  (memReq_out),
        .memAddr_out (memAddr_out),
        .memInstE_in (memInstE_in),
        .memInst_in  (memInst_in)
    );

    always #5 clk_in = ~clk_in;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Issue one fetch; on a miss play memCtrl with a 5-cycle response.
    // Returns whether it hit, whether instE_out pulsed, and the word seen.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] word,
                         output logic was_hit, output logic got_e,
                         output logic [31:0] got_inst, output logic req_seen);
        IFpc_in  = pc;
        IFreq_in = 1'b1;
        tick();
        IFreq_in = 1'b0;
        req_seen = memReq_out;
        was_hit  = 1'b0;
        got_e    = 1'b0;
        got_inst = inst_out;
        if (instE_out) begin
            was_hit = 1'b1;
            got_e   = 1'b1;
        end else if (busy_out) begin
            repeat (4) tick();
            memInstE_in = 1'b1;
            memInst_in  = word;
            tick();
            got_e       = instE_out;
            got_inst    = inst_out;
            memInstE_in = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; IFreq_in = 1'b0; IFpc_in = 32'h0;
        flush_in = 1'b0; memInstE_in = 1'b0; memInst_in = 32'h0;
        repeat (2) tick();
        n_vec++; if (instE_out !== 1'b0) begin n_err++; $display("FAIL reset_instE got=%b exp=0", instE_out); end
        n_vec++; if (inst_out !== 32'h0) begin n_err++; $display("FAIL reset_inst got=%h exp=0", inst_out); end
        n_vec++; if (memReq_out !== 1'b0) begin n_err++; $display("FAIL reset_memReq got=%b exp=0", memReq_out); end
        n_vec++; if (memAddr_out !== 32'h0) begin n_err++; $display("FAIL reset_memAddr got=%h exp=0", memAddr_out); end
        n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy_out); end
        rst_in = 1'b1;
        tick();
        $display("reset done");
    endtask

    task automatic test_cold_miss();
        IFpc_in = 32'h0000_1006;   // low bits must be ignored
        IFreq_in = 1'b1;
        tick();
        IFreq_in = 1'b0;
        n_vec++; if (memReq_out !== 1'b1) begin n_err++; $display("FAIL cold_memReq got=%b exp=1", memReq_out); end
        n_vec++; if (memAddr_out !== 32'h0000_1004) begin n_err++; $display("FAIL cold_memAddr got=%h exp=00001004", memAddr_out); end
        n_vec++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL cold_busy got=%b exp=1", busy_out); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (memReq_out !== 1'b1 || memAddr_out !== 32'h0000_1004 || instE_out !== 1'b0) begin
                n_err++; $display("FAIL cold_hold%0d req=%b addr=%h ie=%b exp req=1 addr=00001004 ie=0", i, memReq_out, memAddr_out, instE_out);
            end
        end
        memInstE_in = 1'b1;
        memInst_in  = 32'h00A0_0093;
        tick();
        n_vec++; if (instE_out !== 1'b1) begin n_err++; $display("FAIL cold_instE got=%b exp=1", instE_out); end
        n_vec++; if (inst_out !== 32'h00A0_0093) begin n_err++; $display("FAIL cold_inst got=%h exp=00a00093", inst_out); end
        n_vec++; if (memReq_out !== 1'b0) begin n_err++; $display("FAIL cold_wait_memReq got=%b exp=0", memReq_out); end
        n_vec++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL cold_wait_busy got=%b exp=1", busy_out); end
        // memCtrl's registered enable still high: must be ignored in WAIT
        memInst_in = 32'hDEAD_BEEF;
        tick();
        memInstE_in = 1'b0;
        n_vec++; if (instE_out !== 1'b0) begin n_err++; $display("FAIL cold_pulse_width got=%b exp=0", instE_out); end
        n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL cold_idle_busy got=%b exp=0", busy_out); end
        n_vec++; if (inst_out !== 32'h00A0_0093) begin n_err++; $display("FAIL cold_inst_hold got=%h exp=00a00093", inst_out); end
        $display("cold miss pc=00001004 inst=%h", inst_out);
    endtask

    task automatic test_hit();
        logic h, e, r;
        logic [31:0] w;
        fetch(32'h0000_1004, 32'hBAD0_0000, h, e, w, r);
        n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL hit_1004 got=%b exp=1", h); end
        n_vec++; if (w !== 32'h00A0_0093) begin n_err++; $display("FAIL hit_1004_data got=%h exp=00a00093", w); end
        n_vec++; if (r !== 1'b0) begin n_err++; $display("FAIL hit_memReq got=%b exp=0", r); end
        $display("hit pc=00001004 inst=%h", w);
        fetch(32'h0000_1008, 32'h1111_1111, h, e, w, r);
        n_vec++; if (h !== 1'b0 || e !== 1'b1 || w !== 32'h1111_1111) begin
            n_err++; $display("FAIL fill_1008 hit=%b ie=%b inst=%h exp hit=0 ie=1 inst=11111111", h, e, w);
        end
        $display("miss pc=00001008 inst=%h", w);
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3];
        logic [31:0] exp [3];
        pcs[0] = 32'h1004; pcs[1] = 32'h1008; pcs[2] = 32'h1004;
        exp[0] = 32'h00A0_0093; exp[1] = 32'h1111_1111; exp[2] = 32'h00A0_0093;
        IFreq_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            IFpc_in = pcs[i];
            tick();
            n_vec++; if (instE_out !== 1'b1 || inst_out !== exp[i] || busy_out !== 1'b0) begin
                n_err++; $display("FAIL b2b_%0d ie=%b inst=%h busy=%b exp ie=1 inst=%h busy=0", i, instE_out, inst_out, busy_out, exp[i]);
            end
            $display("b2b hit pc=%h inst=%h", pcs[i], inst_out);
        end
        IFreq_in = 1'b0;
        tick();
        n_vec++; if (instE_out !== 1'b0) begin n_err++; $display("FAIL b2b_end got=%b exp=0", instE_out); end
    endtask

    task automatic test_conflict();
        logic h, e, r;
        logic [31:0] w;
        fetch(32'h0000_1084, 32'h2222_2222, h, e, w, r);
        n_vec++; if (h !== 1'b0 || e !== 1'b1 || w !== 32'h2222_2222) begin
            n_err++; $display("FAIL conflict_1084 hit=%b ie=%b inst=%h exp hit=0 ie=1 inst=22222222", h, e, w);
        end
        $display("conflict miss pc=00001084 inst=%h", w);
        fetch(32'h0000_1004, 32'h00A0_0093, h, e, w, r);
        n_vec++; if (h !== 1'b0 || e !== 1'b1 || w !== 32'h00A0_0093) begin
            n_err++; $display("FAIL conflict_1004 hit=%b ie=%b inst=%h exp hit=0 ie=1 inst=00a00093", h, e, w);
        end
        $display("conflict miss pc=00001004 inst=%h", w);
        fetch(32'h0000_1084, 32'h2222_2222, h, e, w, r);
        n_vec++; if (h !== 1'b0) begin n_err++; $display("FAIL conflict_1084_again hit=%b exp=0", h); end
        $display("conflict miss pc=00001084 inst=%h", w);
    endtask

    task automatic test_flush();
        logic h, e, r;
        logic [31:0] w;
        // Request and flush together: dropped
        IFpc_in = 32'h0000_2000; IFreq_in = 1'b1; flush_in = 1'b1;
        tick();
        IFreq_in = 1'b0; flush_in = 1'b0;
        n_vec++; if (busy_out !== 1'b0 || memReq_out !== 1'b0 || instE_out !== 1'b0) begin
            n_err++; $display("FAIL flush_same_cycle busy=%b req=%b ie=%b exp 0 0 0", busy_out, memReq_out, instE_out);
        end
        IFreq_in = 1'b1;
        tick();
        IFreq_in = 1'b0;
        tick();
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        n_vec++; if (memReq_out !== 1'b0 || busy_out !== 1'b1) begin
            n_err++; $display("FAIL flush_drop req=%b busy=%b exp req=0 busy=1", memReq_out, busy_out);
        end
        memInstE_in = 1'b1; memInst_in = 32'h3333_3333;
        tick();
        n_vec++; if (busy_out !== 1'b0 || instE_out !== 1'b0) begin
            n_err++; $display("FAIL flush_idle busy=%b ie=%b exp busy=0 ie=0", busy_out, instE_out);
        end
        memInstE_in = 1'b0;
        tick();
        n_vec++; if (instE_out !== 1'b0) begin n_err++; $display("FAIL flush_late_fill ie=%b exp=0", instE_out); end
        fetch(32'h0000_2000, 32'h4444_4444, h, e, w, r);
        n_vec++; if (h !== 1'b0 || w !== 32'h4444_4444) begin
            n_err++; $display("FAIL flush_rerequest hit=%b inst=%h exp hit=0 inst=44444444", h, w);
        end
        $display("flush then miss pc=00002000 inst=%h", w);
    endtask

    task automatic test_rdy();
        IFpc_in = 32'h0000_3000; IFreq_in = 1'b1;
        tick();
        IFreq_in = 1'b0;
        rdy_in = 1'b0;
        memInst_in = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (memReq_out !== 1'b1 || memAddr_out !== 32'h3000 || busy_out !== 1'b1 || instE_out !== 1'b0) begin
                n_err++; $display("FAIL rdy_miss_freeze%0d req=%b addr=%h busy=%b ie=%b", i, memReq_out, memAddr_out, busy_out, instE_out);
            end
        end
        rdy_in = 1'b1;
        tick();
        memInstE_in = 1'b1;
        tick();
        memInstE_in = 1'b0;
        n_vec++; if (instE_out !== 1'b1 || inst_out !== 32'h5555_5555) begin
            n_err++; $display("FAIL rdy_fill ie=%b inst=%h exp ie=1 inst=55555555", instE_out, inst_out);
        end
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (instE_out !== 1'b1 || busy_out !== 1'b1) begin
                n_err++; $display("FAIL rdy_resp_freeze%0d ie=%b busy=%b exp ie=1 busy=1", i, instE_out, busy_out);
            end
        end
        rdy_in = 1'b1;
        tick();
        n_vec++; if (instE_out !== 1'b0 || busy_out !== 1'b0) begin
            n_err++; $display("FAIL rdy_resume ie=%b busy=%b exp 0 0", instE_out, busy_out);
        end
        // Hit response frozen by rdy_in
        IFreq_in = 1'b1;
        tick();
        IFreq_in = 1'b0;
        rdy_in = 1'b0;
        repeat (3) tick();
        n_vec++; if (instE_out !== 1'b1 || inst_out !== 32'h5555_5555) begin
            n_err++; $display("FAIL rdy_hit_freeze ie=%b inst=%h exp ie=1 inst=55555555", instE_out, inst_out);
        end
        rdy_in = 1'b1;
        tick();
        n_vec++; if (instE_out !== 1'b0) begin n_err++; $display("FAIL rdy_hit_release ie=%b exp=0", instE_out); end
        $display("rdy stall pc=00003000 inst=%h", inst_out);
    endtask

    task automatic test_async_reset();
        logic h, e, r;
        logic [31:0] w;
        IFpc_in = 32'h0000_5000; IFreq_in = 1'b1;
        tick();
        IFreq_in = 1'b0;
        tick();
        #2;
        rst_in = 1'b0;
        #1;
        n_vec++; if (memReq_out !== 1'b0 || busy_out !== 1'b0 || memAddr_out !== 32'h0 || inst_out !== 32'h0) begin
            n_err++; $display("FAIL async_reset req=%b busy=%b addr=%h inst=%h exp all 0", memReq_out, busy_out, memAddr_out, inst_out);
        end
        tick();
        rst_in = 1'b1;
        tick();
        fetch(32'h0000_1084, 32'h2222_2222, h, e, w, r);
        n_vec++; if (h !== 1'b0 || w !== 32'h2222_2222) begin
            n_err++; $display("FAIL reset_invalidate hit=%b inst=%h exp hit=0 inst=22222222", h, w);
        end
        $display("async reset then miss pc=00001084 inst=%h", w);
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_back_to_back();
        test_conflict();
        test_flush();
        test_rdy();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
